// File: rtl/core_mem_pkg.sv
// core_mem_pkg
// Shared definitions for the Data Memory load/store paths of the core.
//   - DT_BYTE / DT_WORD : data-type bit (Inst[13]), common to sw/sb and lw/lb/lbu.
//   - BE_LANE0..3, BE_WORD : byte-enable patterns; lane n maps to bits 8n+7:8n.
//   - state_t : load FSM states.
//   - lane_be() : lane number to single-byte enable, used by the store side.
package core_mem_pkg;

  localparam logic DT_BYTE = 1'b0;
  localparam logic DT_WORD = 1'b1;

  localparam logic [3:0] BE_LANE0 = 4'b0001;
  localparam logic [3:0] BE_LANE1 = 4'b0010;
  localparam logic [3:0] BE_LANE2 = 4'b0100;
  localparam logic [3:0] BE_LANE3 = 4'b1000;
  localparam logic [3:0] BE_WORD  = 4'b1111;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    RESP = 3'd3,
    ERR  = 3'd4
  } state_t;

  function automatic logic [3:0] lane_be(input logic [1:0] lane);
    logic [3:0] be;
    case (lane)
      2'd0:    be = BE_LANE0;
      2'd1:    be = BE_LANE1;
      2'd2:    be = BE_LANE2;
      default: be = BE_LANE3;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/load_byte_extract.sv
// load_byte_extract
// Combinational formatter for load data returned by Data Memory.
// Ports:
//   mem_rdata in  32 : raw word read from memory
//   lane      in  2  : byte lane (address bits 1:0)
//   dt        in  1  : DT_WORD returns the word unchanged, DT_BYTE selects a lane
//   sign      in  1  : byte loads only, 1 = sign-extend (lb), 0 = zero-extend (lbu)
//   data      out 32 : formatted write-back value
module load_byte_extract
  import core_mem_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  lane,
  input  logic        dt,
  input  logic        sign,
  output logic [31:0] data
);

  logic [7:0] byte_sel;

  // Lane n occupies bits 8n+7:8n, matching the store byte enables.
  always_comb begin
    byte_sel = 8'h00;
    case (lane)
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
  end

  always_comb begin
    data = mem_rdata;
    if (dt == DT_BYTE) begin
      if (sign) data = {{24{byte_sel[7]}}, byte_sel};
      else      data = {24'h000000, byte_sel};
    end
  end

endmodule

// File: rtl/load_align_unit.sv
// load_align_unit
// Multi-cycle load path to Data Memory for lw/lb/lbu. A request accepted in
// IDLE is issued as a single word-aligned read strobe; the returned word is
// formatted (lane select + sign/zero extension) and written back with the
// destination tag. Misaligned words and memory timeouts raise ld_err.
//
// Handshake: ld_req is looked at only while stall is low (state IDLE); the
// upstream stage keeps it asserted while stall is high. mem_rd_en is a
// one-cycle strobe; mem_rvalid is accepted only in WAIT, at least one cycle
// after the strobe, and is ignored in every other state. wb_valid and ld_err
// are one-cycle pulses and are mutually exclusive.
//
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   ld_req, ld_addr       : load request and byte address
//   ld_dt, ld_sign, ld_tag: word/byte, sign/zero extend, destination register
//   mem_rd_en, mem_addr   : read strobe and word-aligned address to memory
//   mem_rdata, mem_rvalid : read data returned from memory
//   stall                 : high while the unit is busy (state != IDLE)
//   wb_valid, wb_data, wb_tag : write-back pulse, value and destination
//   ld_err                : error pulse (misaligned word or timeout)
//   dbg_state             : current FSM state encoding
module load_align_unit
  import core_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,  // legal range 2..255
  parameter int TAG_W          = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld_req,
  input  logic [31:0]      ld_addr,
  input  logic             ld_dt,
  input  logic             ld_sign,
  input  logic [TAG_W-1:0] ld_tag,
  output logic             mem_rd_en,
  output logic [31:0]      mem_addr,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_rvalid,
  output logic             stall,
  output logic             wb_valid,
  output logic [31:0]      wb_data,
  output logic [TAG_W-1:0] wb_tag,
  output logic             ld_err,
  output logic [2:0]       dbg_state
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t           state, next_state;
  logic [7:0]       cnt;
  logic [1:0]       lane_q;
  logic             dt_q;
  logic             sign_q;
  logic [TAG_W-1:0] tag_q;
  logic [31:0]      fmt_data;

  logic             misaligned;
  logic             accept;
  logic             mem_rd_en_d;
  logic             wb_valid_d;
  logic             ld_err_d;

  assign misaligned = (ld_dt == DT_WORD) && (ld_addr[1:0] != 2'b00);
  assign accept     = (state == IDLE) && ld_req && !misaligned;

  assign stall     = (state != IDLE);
  assign dbg_state = state;

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (ld_req) next_state = misaligned ? ERR : REQ;
      end
      REQ:  next_state = WAIT;
      WAIT: begin
        // Data arriving on the terminal count still wins over the timeout.
        if (mem_rvalid)           next_state = RESP;
        else if (cnt == CNT_LAST) next_state = ERR;
      end
      RESP: next_state = IDLE;
      ERR:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // ---------------- output logic ----------------
  // Pulses are decoded from the upcoming state and registered, so each one
  // is high exactly during the cycle spent in the matching state.
  always_comb begin
    mem_rd_en_d = (next_state == REQ);
    wb_valid_d  = (next_state == RESP);
    ld_err_d    = (next_state == ERR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rd_en <= 1'b0;
      wb_valid  <= 1'b0;
      ld_err    <= 1'b0;
    end else begin
      mem_rd_en <= mem_rd_en_d;
      wb_valid  <= wb_valid_d;
      ld_err    <= ld_err_d;
    end
  end

  // ---------------- request latch ----------------
  // mem_addr only changes on acceptance, so it is stable through REQ and WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q   <= 2'b00;
      dt_q     <= DT_BYTE;
      sign_q   <= 1'b0;
      tag_q    <= '0;
      mem_addr <= 32'h0;
    end else if (accept) begin
      lane_q   <= ld_addr[1:0];
      dt_q     <= ld_dt;
      sign_q   <= ld_sign;
      tag_q    <= ld_tag;
      mem_addr <= {ld_addr[31:2], 2'b00};
    end
  end

  // ---------------- timeout counter ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 8'h00;
    end else if (state == REQ) begin
      cnt <= 8'h00;
    end else if (state == WAIT && !mem_rvalid) begin
      cnt <= cnt + 8'h01;
    end
  end

  // ---------------- data formatting and write-back ----------------
  load_byte_extract u_extract (
    .mem_rdata (mem_rdata),
    .lane      (lane_q),
    .dt        (dt_q),
    .sign      (sign_q),
    .data      (fmt_data)
  );

  // wb_data/wb_tag hold their last values; ERR leaves them untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_data <= 32'h0;
      wb_tag  <= '0;
    end else if (state == WAIT && mem_rvalid) begin
      wb_data <= fmt_data;
      wb_tag  <= tag_q;
    end
  end

endmodule

// File: tb/tb_load_align_unit.sv
module tb_load_align_unit;

  localparam int T     = 4;
  localparam int TAG_W = 5;

  logic             clk;
  logic             rst_n;
  logic             ld_req;
  logic [31:0]      ld_addr;
  logic             ld_dt;
  logic             ld_sign;
  logic [TAG_W-1:0] ld_tag;
  logic             mem_rd_en;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_rdata;
  logic             mem_rvalid;
  logic             stall;
  logic             wb_valid;
  logic [31:0]      wb_data;
  logic [TAG_W-1:0] wb_tag;
  logic             ld_err;
  logic [2:0]       dbg_state;

  int checks = 0;
  int errors = 0;

  logic [31:0]      exp_q[$];
  logic [TAG_W-1:0] exp_tag_q[$];
  logic [31:0]      model_wb;  // value wb_data should currently hold

  load_align_unit #(.TIMEOUT_CYCLES(T), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld_req     (ld_req),
    .ld_addr    (ld_addr),
    .ld_dt      (ld_dt),
    .ld_sign    (ld_sign),
    .ld_tag     (ld_tag),
    .mem_rd_en  (mem_rd_en),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .stall      (stall),
    .wb_valid   (wb_valid),
    .wb_data    (wb_data),
    .wb_tag     (wb_tag),
    .ld_err     (ld_err),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock/reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] model_fmt(input logic [31:0] rdata, input logic [31:0] addr,
                                            input logic dt, input logic sign);
    int unsigned b;
    if (dt) return rdata;
    b = (rdata >> (8 * addr[1:0])) & 32'hFF;
    if (sign && b >= 128) return b + 32'hFFFFFF00;
    return b;
  endfunction

  // Expected cycle (relative to the request cycle 0) of wb_valid / ld_err; -1 = never.
  function automatic int model_wb_t(input logic [31:0] addr, input logic dt, input int lat);
    if (dt && addr[1:0] != 0) return -1;
    if (lat <= T) return lat + 2;
    return -1;
  endfunction

  function automatic int model_err_t(input logic [31:0] addr, input logic dt, input int lat);
    if (dt && addr[1:0] != 0) return 1;
    if (lat <= T) return -1;
    return T + 2;
  endfunction

  // ---------------- driver ----------------
  // Called right after a negedge with the unit idle. Presents one request,
  // answers the read strobe with rvalid 'lat' cycles later, and records what
  // the DUT did. Returns at a negedge with the unit idle again.
  task automatic drive_load(input logic [31:0] addr, input logic dt, input logic sign,
                            input logic [TAG_W-1:0] tag, input logic [31:0] rdata, input int lat,
                            output int wb_t, output int err_t, output int n_rd,
                            output logic [31:0] rd_addr, output logic [31:0] data,
                            output logic [TAG_W-1:0] tag_o, output int n_stall, output bit done);
    wb_t = -1; err_t = -1; n_rd = 0; rd_addr = 0; data = 0; tag_o = 0; n_stall = 0; done = 0;
    ld_req = 1'b1; ld_addr = addr; ld_dt = dt; ld_sign = sign; ld_tag = tag;
    for (int t = 1; t <= 40; t++) begin
      @(negedge clk);
      if (t == 1) ld_req = 1'b0;
      if (stall) n_stall++;
      if (mem_rd_en) begin n_rd++; rd_addr = mem_addr; end
      if (wb_valid) begin wb_t = t; data = wb_data; tag_o = wb_tag; end
      if (ld_err) err_t = t;
      if (t == 1 + lat) begin
        mem_rvalid = 1'b1; mem_rdata = rdata;
      end else begin
        mem_rvalid = 1'b0; mem_rdata = $urandom;
      end
      if (t > 1 && !stall) begin done = 1; break; end
    end
    mem_rvalid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; ld_req = 0; ld_addr = 0; ld_dt = 0; ld_sign = 0; ld_tag = 0;
    mem_rdata = 0; mem_rvalid = 0;
    repeat (2) @(negedge clk);
    checks++; if (stall !== 1'b0)     begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
    checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b want 0", mem_rd_en); end
    checks++; if (wb_valid !== 1'b0)  begin errors++; $display("FAIL reset_wb_valid got %b want 0", wb_valid); end
    checks++; if (ld_err !== 1'b0)    begin errors++; $display("FAIL reset_ld_err got %b want 0", ld_err); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
    checks++; if (wb_data !== 32'h0)  begin errors++; $display("FAIL reset_wb_data got %h want 0", wb_data); end
    checks++; if (wb_tag !== '0)      begin errors++; $display("FAIL reset_wb_tag got %h want 0", wb_tag); end
    rst_n = 1'b1;
    model_wb = 32'h0;
    @(negedge clk);
  endtask

  task automatic test_lw();
    int wb_t, err_t, n_rd, n_stall; logic [31:0] rd_addr, data; logic [TAG_W-1:0] tg; bit done;
    drive_load(32'h100, 1'b1, 1'b0, 5'd9, 32'hDEADBEEF, 1, wb_t, err_t, n_rd, rd_addr, data, tg, n_stall, done);
    model_wb = 32'hDEADBEEF;
    checks++; if (done !== 1'b1)      begin errors++; $display("FAIL lw_done got %b want 1", done); end
    checks++; if (n_rd != 1)          begin errors++; $display("FAIL lw_rd_pulses got %0d want 1", n_rd); end
    checks++; if (rd_addr !== 32'h100) begin errors++; $display("FAIL lw_mem_addr got %h want 100", rd_addr); end
    checks++; if (wb_t != 3)          begin errors++; $display("FAIL lw_latency got %0d want 3", wb_t); end
    checks++; if (data !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data got %h want deadbeef", data); end
    checks++; if (tg !== 5'd9)        begin errors++; $display("FAIL lw_tag got %0d want 9", tg); end
    checks++; if (n_stall != 3)       begin errors++; $display("FAIL lw_stall_cycles got %0d want 3", n_stall); end
    checks++; if (err_t != -1)        begin errors++; $display("FAIL lw_no_err got %0d want -1", err_t); end
  endtask

  task automatic test_byte_loads();
    int wb_t, err_t, n_rd, n_stall; logic [31:0] rd_addr, data; logic [TAG_W-1:0] tg; bit done;
    logic [31:0] addrs[3]; logic signs[3]; logic [31:0] want[3];
    addrs = '{32'h103, 32'h101, 32'h103};
    signs = '{1'b1, 1'b1, 1'b0};
    want  = '{32'hFFFFFF80, 32'h0000007F, 32'h00000080};
    for (int i = 0; i < 3; i++) begin
      drive_load(addrs[i], 1'b0, signs[i], 5'(i + 3), 32'h80FF7F01, 2, wb_t, err_t, n_rd, rd_addr, data, tg, n_stall, done);
      model_wb = want[i];
      checks++; if (data !== want[i]) begin errors++; $display("FAIL byte_data_%0d got %h want %h", i, data, want[i]); end
      checks++; if (rd_addr !== 32'h100) begin errors++; $display("FAIL byte_addr_%0d got %h want 100", i, rd_addr); end
      checks++; if (wb_t != 4) begin errors++; $display("FAIL byte_latency_%0d got %0d want 4", i, wb_t); end
      checks++; if (tg !== 5'(i + 3)) begin errors++; $display("FAIL byte_tag_%0d got %0d want %0d", i, tg, i + 3); end
    end
  endtask

  task automatic test_misaligned();
    int wb_t, err_t, n_rd, n_stall; logic [31:0] rd_addr, data; logic [TAG_W-1:0] tg; bit done;
    drive_load(32'h102, 1'b1, 1'b0, 5'd4, 32'h12345678, 1, wb_t, err_t, n_rd, rd_addr, data, tg, n_stall, done);
    checks++; if (err_t != 1)   begin errors++; $display("FAIL mis_err_cycle got %0d want 1", err_t); end
    checks++; if (n_rd != 0)    begin errors++; $display("FAIL mis_rd_pulses got %0d want 0", n_rd); end
    checks++; if (wb_t != -1)   begin errors++; $display("FAIL mis_wb got %0d want -1", wb_t); end
    checks++; if (n_stall != 1) begin errors++; $display("FAIL mis_stall_cycles got %0d want 1", n_stall); end
    checks++; if (wb_data !== model_wb) begin errors++; $display("FAIL mis_wb_hold got %h want %h", wb_data, model_wb); end
  endtask

  task automatic test_timeout();
    int wb_t, err_t, n_rd, n_stall; logic [31:0] rd_addr, data; logic [TAG_W-1:0] tg; bit done;
    drive_load(32'h40, 1'b1, 1'b0, 5'd2, 32'hCAFEF00D, 99, wb_t, err_t, n_rd, rd_addr, data, tg, n_stall, done);
    checks++; if (err_t != T + 2) begin errors++; $display("FAIL tmo_err_cycle got %0d want %0d", err_t, T + 2); end
    checks++; if (wb_t != -1)     begin errors++; $display("FAIL tmo_wb got %0d want -1", wb_t); end
    checks++; if (wb_data !== model_wb) begin errors++; $display("FAIL tmo_wb_hold got %h want %h", wb_data, model_wb); end
    // rvalid on the terminal-count cycle still completes the load
    drive_load(32'h44, 1'b1, 1'b0, 5'd6, 32'h0BADCAFE, T, wb_t, err_t, n_rd, rd_addr, data, tg, n_stall, done);
    model_wb = 32'h0BADCAFE;
    checks++; if (wb_t != T + 2) begin errors++; $display("FAIL tc_wb_cycle got %0d want %0d", wb_t, T + 2); end
    checks++; if (err_t != -1)   begin errors++; $display("FAIL tc_no_err got %0d want -1", err_t); end
    checks++; if (data !== 32'h0BADCAFE) begin errors++; $display("FAIL tc_data got %h want 0badcafe", data); end
  endtask

  task automatic test_reset_mid_load();
    int wb_t, err_t, n_rd, n_stall; logic [31:0] rd_addr, data; logic [TAG_W-1:0] tg; bit done;
    bit seen;
    ld_req = 1'b1; ld_addr = 32'h200; ld_dt = 1'b1; ld_sign = 1'b0; ld_tag = 5'd7;
    @(negedge clk); ld_req = 1'b0;
    @(negedge clk);  // now waiting for data
    rst_n = 1'b0;
    #1;
    model_wb = 32'h0;
    checks++; if (stall !== 1'b0 || mem_rd_en !== 1'b0 || wb_valid !== 1'b0 || ld_err !== 1'b0)
      begin errors++; $display("FAIL rstmid_ctrl got stall=%b rd=%b wbv=%b err=%b want 0", stall, mem_rd_en, wb_valid, ld_err); end
    checks++; if (mem_addr !== 32'h0 || wb_data !== 32'h0 || wb_tag !== '0)
      begin errors++; $display("FAIL rstmid_data got addr=%h data=%h tag=%h want 0", mem_addr, wb_data, wb_tag); end
    @(negedge clk);
    rst_n = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h55AA55AA;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      if (wb_valid || ld_err || stall) seen = 1;
    end
    checks++; if (seen) begin errors++; $display("FAIL rstmid_stray_rvalid got activity want none"); end
    drive_load(32'h204, 1'b1, 1'b0, 5'd11, 32'h13579BDF, 1, wb_t, err_t, n_rd, rd_addr, data, tg, n_stall, done);
    model_wb = 32'h13579BDF;
    checks++; if (wb_t != 3 || data !== 32'h13579BDF || tg !== 5'd11)
      begin errors++; $display("FAIL rstmid_fresh got t=%0d data=%h tag=%0d want 3/13579bdf/11", wb_t, data, tg); end
  endtask

  task automatic test_back_to_back();
    int rd_t[$]; int wb_ts[$]; int resp_t; logic [31:0] rdat[2]; int n_resp;
    logic [TAG_W-1:0] et; logic [31:0] ed;
    rdat = '{32'h11223344, 32'h0000AB00};
    exp_q.push_back(model_fmt(rdat[0], 32'h300, 1'b1, 1'b0)); exp_tag_q.push_back(5'd20);
    exp_q.push_back(model_fmt(rdat[1], 32'h301, 1'b0, 1'b0)); exp_tag_q.push_back(5'd21);
    resp_t = -1; n_resp = 0;
    ld_req = 1'b1; ld_addr = 32'h300; ld_dt = 1'b1; ld_sign = 1'b0; ld_tag = 5'd20;
    for (int t = 1; t <= 30; t++) begin
      @(negedge clk);
      if (mem_rd_en) begin rd_t.push_back(t); resp_t = t + 1; if (rd_t.size() == 2) ld_req = 1'b0; end
      if (wb_valid) begin
        wb_ts.push_back(t);
        if (exp_q.size() == 0) begin
          checks++; errors++; $display("FAIL b2b_extra_wb got wb_valid at %0d want none", t);
        end else begin
          et = exp_tag_q.pop_front(); ed = exp_q.pop_front(); model_wb = ed;
          checks++; if (wb_tag !== et) begin errors++; $display("FAIL b2b_tag got %0d want %0d", wb_tag, et); end
          checks++; if (wb_data !== ed) begin errors++; $display("FAIL b2b_data got %h want %h", wb_data, ed); end
        end
      end
      if (t == 1) begin ld_addr = 32'h301; ld_dt = 1'b0; ld_tag = 5'd21; end
      if (t == resp_t) begin mem_rvalid = 1'b1; mem_rdata = rdat[n_resp]; n_resp++; end
      else mem_rvalid = 1'b0;
      if (wb_ts.size() == 2 && !stall) break;
    end
    ld_req = 1'b0; mem_rvalid = 1'b0;
    checks++; if (rd_t.size() != 2 || rd_t[0] != 1 || rd_t[1] != 5)
      begin errors++; $display("FAIL b2b_rd_cycles got n=%0d want 1,5", rd_t.size()); end
    checks++; if (wb_ts.size() != 2 || wb_ts[0] != 3 || wb_ts[1] != 7)
      begin errors++; $display("FAIL b2b_wb_cycles got n=%0d want 3,7", wb_ts.size()); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_missing_wb got %0d pending want 0", exp_q.size()); end
    exp_q.delete(); exp_tag_q.delete();
    @(negedge clk);
  endtask

  task automatic test_random();
    int wb_t, err_t, n_rd, n_stall; logic [31:0] rd_addr, data; logic [TAG_W-1:0] tg; bit done;
    logic [31:0] addr, rdata, ed; logic dt, sign; logic [TAG_W-1:0] tag; int lat;
    int ewb, eerr;
    for (int i = 0; i < 30; i++) begin
      addr = $urandom; dt = 1'($urandom_range(0, 1)); sign = 1'($urandom_range(0, 1));
      tag = TAG_W'($urandom); rdata = $urandom; lat = $urandom_range(1, T + 2);
      if ($urandom_range(0, 3) != 0 && dt) addr[1:0] = 2'b00;
      ewb = model_wb_t(addr, dt, lat); eerr = model_err_t(addr, dt, lat);
      if (ewb >= 0) exp_q.push_back(model_fmt(rdata, addr, dt, sign));
      drive_load(addr, dt, sign, tag, rdata, lat, wb_t, err_t, n_rd, rd_addr, data, tg, n_stall, done);
      checks++; if (wb_t != ewb || err_t != eerr || !done)
        begin errors++; $display("FAIL rnd_%0d_timing got wb=%0d err=%0d want wb=%0d err=%0d", i, wb_t, err_t, ewb, eerr); end
      checks++; if (n_rd != ((eerr == 1) ? 0 : 1) || (n_rd == 1 && rd_addr !== (addr & 32'hFFFFFFFC)))
        begin errors++; $display("FAIL rnd_%0d_read got n=%0d addr=%h want addr=%h", i, n_rd, rd_addr, addr & 32'hFFFFFFFC); end
      if (ewb >= 0) begin
        ed = exp_q.pop_front(); model_wb = ed;
        checks++; if (data !== ed || tg !== tag)
          begin errors++; $display("FAIL rnd_%0d_wb got %h/%0d want %h/%0d", i, data, tg, ed, tag); end
      end
      checks++; if (wb_data !== model_wb)
        begin errors++; $display("FAIL rnd_%0d_hold got %h want %h", i, wb_data, model_wb); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_lw();
    test_byte_loads();
    test_misaligned();
    test_timeout();
    test_reset_mid_load();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_align_unit.md
Name: load_align_unit

Overview:
- Multi-cycle load path for the single-cycle-datapath core's Data Memory; the read-side counterpart of the sw/sb store byte-enable logic.
- Accepts lw/lb/lbu requests and issues a word-aligned read to Data Memory with a request/valid handshake.
- Extracts and sign- or zero-extends the addressed byte lane, then returns the write-back result with a destination tag.
- Stalls the pipeline while a load is outstanding and flags misaligned words and memory timeouts.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles spent in WAIT before abort (range 2..255).
- TAG_W, 5: width of the destination-register tag.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- ld_req  in  1  load request; sampled only in IDLE.
- ld_addr  in  32  byte address (ALU result).
- ld_dt  in  1  1 = word (lw), 0 = byte (lb/lbu); same encoding as the store DT bit, Inst[13].
- ld_sign  in  1  byte loads only: 1 = sign-extend (lb), 0 = zero-extend (lbu).
- ld_tag  in  TAG_W  destination register number.
- mem_rd_en  out  1  one-cycle read strobe to Data Memory.
- mem_addr  out  32  word-aligned read address, {ld_addr[31:2], 2'b00}.
- mem_rdata  in  32  read data.
- mem_rvalid  in  1  read data valid.
- stall  out  1  high while the unit is not in IDLE.
- wb_valid  out  1  one-cycle write-back strobe.
- wb_data  out  32  loaded value.
- wb_tag  out  TAG_W  destination register for wb_data.
- ld_err  out  1  one-cycle error pulse (misaligned or timeout).

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE.
  - mem_rd_en, wb_valid, ld_err, stall = 0.
  - mem_addr, wb_data = 0; wb_tag = 0.
  - timeout counter = 0.
  - Reset mid-load aborts the load; no write-back, no error pulse.
- All outputs are registered. stall is decoded from the state register (state != IDLE).
- IDLE:
  - ld_req=1, ld_dt=1, ld_addr[1:0]!=0 -> ERR. Nothing is issued to memory.
  - Otherwise ld_req=1 -> REQ. Latch lane=ld_addr[1:0], dt, sign, tag; mem_addr = {ld_addr[31:2], 2'b00}.
- REQ:
  - mem_rd_en=1 for exactly this cycle; mem_addr is held stable from REQ through WAIT.
  - Next state WAIT; counter cleared.
  - mem_rvalid is ignored in REQ. Memory latency is at least 1 cycle after the strobe.
- WAIT:
  - mem_rvalid=1 -> RESP. Capture the formatted data.
  - Else counter+1. When the counter reaches TIMEOUT_CYCLES-1 with no rvalid -> ERR.
  - mem_rvalid in the same cycle as the terminal count: data wins, go RESP.
- Formatting:
  - Word: wb_data = mem_rdata.
  - Byte: b = mem_rdata[8*lane+7 : 8*lane]. Lane 0 = bits 7:0 (store BE 0001) … lane 3 = bits 31:24 (BE 1000).
  - wb_data = ld_sign ? {{24{b[7]}}, b} : {24'b0, b}.
- RESP: wb_valid=1 and wb_tag = latched tag for one cycle; next state IDLE. wb_data holds until the next RESP.
- ERR: ld_err=1 for one cycle; wb_valid=0; next state IDLE. wb_data is unchanged.
- Latency: request accepted in cycle 0; REQ in 1; data at earliest in WAIT, cycle 2; wb_valid in cycle 3. That is 3 cycles minimum, i.e. mem latency + 2.
- Back-to-back: the first ld_req can be accepted in the cycle after RESP/ERR, when the unit is back in IDLE.
- ld_req while stall=1 is ignored. The upstream stage holds the request while stall is high.
- Stray mem_rvalid in IDLE, REQ, RESP or ERR is ignored.

Decomposition:
- Shared package core_mem_pkg:
  - DT_BYTE=1'b0, DT_WORD=1'b1.
  - State enum {IDLE, REQ, WAIT, RESP, ERR}.
  - Lane-to-byte-enable constants BE_LANE0..3 = 0001/0010/0100/1000, BE_WORD=1111, shared with the store side.
- One natural combinational sub-module: load_byte_extract (mem_rdata, lane, dt, sign -> formatted 32-bit word). The FSM and timeout counter stay in the top.

Test Plan:
- lw at 0x100, mem_rdata=0xDEADBEEF after 1 cycle -> mem_rd_en pulse, mem_addr=0x100, wb_valid 3 cycles after the request, wb_data=0xDEADBEEF, wb_tag echoed, stall high for 3 cycles.
- lb at 0x103 and 0x101, rdata=0x80FF7F01 -> lane3 wb_data=0xFFFFFF80; lane1 wb_data=0x0000007F. lbu at 0x103 -> 0x00000080.
- lw at 0x102 -> ld_err 1-cycle pulse, no mem_rd_en, no wb_valid, back to IDLE after 2 cycles.
- No rvalid, TIMEOUT_CYCLES=4 -> ld_err after 4 WAIT cycles, wb_valid never set. Second case: rvalid on the terminal-count cycle -> RESP, no ld_err.
- rst_n low during WAIT -> immediate IDLE, all outputs 0. A later rvalid is ignored; a fresh lw completes normally.
- Two lw's issued back-to-back with the second held during stall -> second mem_rd_en the cycle after IDLE is re-entered, two wb_valid pulses with correct tags.
